// File: rtl/aq_clint_apbslv.sv
// CLINT APB completer: msip, mtimecmp and a free-running 64-bit mtime with
// programmable wait states and perr on unmapped or unprivileged accesses.
module aq_clint_apbslv #(
    parameter int unsigned WAIT_CYC  = 0,
    parameter bit          PRIV_ONLY = 1'b1
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [1:0]  pprot,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        perr,
    input  logic        time_tick,
    output logic        clint_msip,
    output logic        clint_mtip
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [13:0] A_MSIP  = 14'h0000;
    localparam logic [13:0] A_CMPLO = 14'h1000;
    localparam logic [13:0] A_CMPHI = 14'h1001;
    localparam logic [13:0] A_TIMLO = 14'h2FFE;
    localparam logic [13:0] A_TIMHI = 14'h2FFF;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        capture;
    logic        commit;
    logic [13:0] waddr;
    logic        mapped;
    logic        acc_err;
    logic [31:0] rd_mux;
    logic        msip, msip_nxt;
    logic [63:0] mtime, mtime_nxt;
    logic [63:0] mtimecmp, mtimecmp_nxt;
    logic        unused_bits;

    assign waddr       = paddr[15:2];
    assign unused_bits = ^{paddr[31:16], paddr[1:0], pprot[1]};
    assign pready      = (state == RESP);
    assign clint_msip  = msip;

    always_comb begin
        mapped = 1'b1;
        rd_mux = '0;
        case (waddr)
            A_MSIP:  rd_mux = {31'b0, msip};
            A_CMPLO: rd_mux = mtimecmp[31:0];
            A_CMPHI: rd_mux = mtimecmp[63:32];
            A_TIMLO: rd_mux = mtime[31:0];
            A_TIMHI: rd_mux = mtime[63:32];
            default: mapped = 1'b0;
        endcase
        acc_err = !mapped || (PRIV_ONLY && !pprot[0]);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    cnt_nxt = 3'(WAIT_CYC);
                    if (WAIT_CYC > 0) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = RESP;
                        capture   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_nxt = RESP;
                        capture   = 1'b1;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // perr was captured with the same address, so it gates the commit
    assign commit = (state == RESP) && psel && penable && pwrite && !perr;

    always_comb begin
        msip_nxt     = msip;
        mtimecmp_nxt = mtimecmp;
        mtime_nxt    = mtime + 64'(time_tick);
        if (commit) begin
            case (waddr)
                A_MSIP:  msip_nxt = pwdata[0];
                A_CMPLO: mtimecmp_nxt[31:0]  = pwdata;
                A_CMPHI: mtimecmp_nxt[63:32] = pwdata;
                A_TIMLO: mtime_nxt = {mtime[63:32], pwdata};
                A_TIMHI: mtime_nxt = {pwdata, mtime[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state      <= IDLE;
            cnt        <= '0;
            prdata     <= '0;
            perr       <= 1'b0;
            msip       <= 1'b0;
            mtime      <= '0;
            mtimecmp   <= '1;
            clint_mtip <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            msip       <= msip_nxt;
            mtime      <= mtime_nxt;
            mtimecmp   <= mtimecmp_nxt;
            clint_mtip <= (mtime >= mtimecmp);
            if (capture) begin
                prdata <= acc_err ? 32'h0 : rd_mux;
                perr   <= acc_err;
            end
        end
    end

endmodule

// File: tb/tb_aq_clint_apbslv.sv
// Directed bench for aq_clint_apbslv: two instances (WAIT_CYC 0 and 3) checked
// against a transaction-level register model plus hand-computed literals.
module tb_aq_clint_apbslv;

    logic        clk = 1'b0;
    logic        cpurst_b;
    logic        psel_r, penable, pwrite, time_tick;
    logic [31:0] paddr, pwdata;
    logic [1:0]  pprot;
    int          cur;

    logic        psel0, psel1;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, perr0, perr1;
    logic        msip0, msip1, mtip0, mtip1;

    int n_chk = 0;
    int n_err = 0;

    // model state
    logic        m_msip[2];
    logic [63:0] m_mtime[2];
    logic [63:0] m_cmp[2];
    logic        e_mtip[2];
    logic        do_commit = 1'b0;
    int          c_i;
    logic [31:0] c_a, c_d;
    logic        chk_en = 1'b0;

    always #5 clk = ~clk;

    assign psel0 = psel_r && (cur == 0);
    assign psel1 = psel_r && (cur == 1);

    aq_clint_apbslv #(.WAIT_CYC(0), .PRIV_ONLY(1'b1)) dut0 (
        .forever_cpuclk(clk), .cpurst_b(cpurst_b), .psel(psel0), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pprot(pprot),
        .prdata(prdata0), .pready(pready0), .perr(perr0), .time_tick(time_tick),
        .clint_msip(msip0), .clint_mtip(mtip0)
    );

    aq_clint_apbslv #(.WAIT_CYC(3), .PRIV_ONLY(1'b1)) dut1 (
        .forever_cpuclk(clk), .cpurst_b(cpurst_b), .psel(psel1), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pprot(pprot),
        .prdata(prdata1), .pready(pready1), .perr(perr1), .time_tick(time_tick),
        .clint_msip(msip1), .clint_mtip(mtip1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int i);
        return (i == 0) ? pready0 : pready1;
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] prot);
        logic [15:0] w;
        w = a[15:0] & 16'hFFFC;
        if (!prot[0]) return 1'b1;
        return !(w == 16'h0000 || w == 16'h4000 || w == 16'h4004 ||
                 w == 16'hBFF8 || w == 16'hBFFC);
    endfunction

    function automatic logic [31:0] model_read(input int i, input logic [31:0] a,
                                               input logic [1:0] prot);
        if (model_err(a, prot)) return '0;
        case (a[15:0] & 16'hFFFC)
            16'h0000: return {31'b0, m_msip[i]};
            16'h4000: return m_cmp[i][31:0];
            16'h4004: return m_cmp[i][63:32];
            16'hBFF8: return m_mtime[i][31:0];
            16'hBFFC: return m_mtime[i][63:32];
            default:  return '0;
        endcase
    endfunction

    // register model: timer compare uses the pre-edge values, writes beat ticks
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cpurst_b) begin
                m_msip[i]  = 1'b0;
                m_mtime[i] = 64'h0;
                m_cmp[i]   = '1;
                e_mtip[i]  = 1'b0;
            end else begin
                logic        hit;
                logic [15:0] w;
                hit = do_commit && (c_i == i);
                w   = c_a[15:0] & 16'hFFFC;
                e_mtip[i] = (m_mtime[i] >= m_cmp[i]);
                if (time_tick && !(hit && (w == 16'hBFF8 || w == 16'hBFFC)))
                    m_mtime[i] = m_mtime[i] + 64'd1;
                if (hit) begin
                    case (w)
                        16'h0000: m_msip[i] = c_d[0];
                        16'h4000: m_cmp[i][31:0]    = c_d;
                        16'h4004: m_cmp[i][63:32]   = c_d;
                        16'hBFF8: m_mtime[i][31:0]  = c_d;
                        16'hBFFC: m_mtime[i][63:32] = c_d;
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("msip0", msip0, m_msip[0]);
            chk("msip1", msip1, m_msip[1]);
            chk("mtip0", mtip0, e_mtip[0]);
            chk("mtip1", mtip1, e_mtip[1]);
        end
    end

    task automatic apb(input int i, input logic [31:0] a, input logic wr,
                       input logic [31:0] wd, input logic [1:0] prot, input bit tick_resp,
                       output logic [31:0] rd, output logic er);
        logic [31:0] pred;
        int          cyc;
        bit          done;
        @(posedge clk); #1;
        cur = i; psel_r = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd; pprot = prot;
        @(negedge clk);
        pred = model_read(i, a, prot);
        @(posedge clk); #1;
        penable = 1'b1;
        cyc  = 1;
        done = 1'b0;
        rd   = '0;
        er   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rdy(i)) begin
                done = 1'b1;
                rd = (i == 0) ? prdata0 : prdata1;
                er = (i == 0) ? perr0 : perr1;
                chk("latency", 64'(cyc), (i == 0) ? 64'd1 : 64'd4);
                chk("prdata", rd, pred);
                chk("perr", er, model_err(a, prot));
                if (wr && !model_err(a, prot)) begin
                    do_commit = 1'b1; c_i = i; c_a = a; c_d = wd;
                end
                if (tick_resp) time_tick = 1'b1;
            end else if (cyc >= 12) begin
                done = 1'b1;
                n_chk++; n_err++;
                $display("FAIL pready_timeout: got 0 expected 1 within 12 cycles");
            end else begin
                pred = model_read(i, a, prot);
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        psel_r = 1'b0; penable = 1'b0; pwrite = 1'b0; do_commit = 1'b0; time_tick = 1'b0;
        @(negedge clk);
        chk("pready_one_cycle", rdy(i), 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1; time_tick = 1'b1;
            @(posedge clk); #1; time_tick = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        cpurst_b = 1'b0; psel_r = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pprot = 2'b01; time_tick = 1'b0; cur = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready0", pready0, 1'b0);
        chk("rst_pready1", pready1, 1'b0);
        chk("rst_prdata0", prdata0, 32'h0);
        chk("rst_perr0", perr0, 1'b0);
        chk("rst_msip0", msip0, 1'b0);
        chk("rst_mtip0", mtip0, 1'b0);
        @(posedge clk); #1; cpurst_b = 1'b1; chk_en = 1'b1;

        apb(0, 32'h4004, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("cmp_hi_reset", rd, 32'hFFFF_FFFF);
        chk("cmp_hi_perr", er, 1'b0);
        chk("mtip_after_reset", mtip0, 1'b0);

        apb(0, 32'h0000, 1'b1, 32'h5, 2'b01, 1'b0, rd, er);
        chk("msip_set", msip0, 1'b1);
        apb(0, 32'h0000, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("msip_read", rd, 32'h1);

        apb(0, 32'hBFF8, 1'b1, 32'hFFFF_FFFE, 2'b01, 1'b0, rd, er);
        apb(0, 32'hBFFC, 1'b1, 32'h0, 2'b01, 1'b0, rd, er);
        ticks(3);
        apb(0, 32'hBFFC, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("mtime_carry_hi", rd, 32'h1);
        apb(0, 32'hBFF8, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("mtime_carry_lo", rd, 32'h1);

        apb(0, 32'hBFFC, 1'b1, 32'h0, 2'b01, 1'b0, rd, er);
        apb(0, 32'h4004, 1'b1, 32'h0, 2'b01, 1'b0, rd, er);
        apb(0, 32'h4000, 1'b1, 32'h10, 2'b01, 1'b0, rd, er);
        apb(0, 32'hBFF8, 1'b1, 32'hF, 2'b01, 1'b0, rd, er);
        chk("mtip_below", mtip0, 1'b0);
        ticks(1);
        @(negedge clk);
        chk("mtip_same_cycle", mtip0, 1'b0);
        @(negedge clk);
        chk("mtip_rise", mtip0, 1'b1);

        apb(1, 32'hBFF8, 1'b1, 32'h100, 2'b01, 1'b1, rd, er);
        apb(1, 32'hBFF8, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("w3_mtime_lo", rd, 32'h100);
        apb(1, 32'hBFFC, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("w3_mtime_hi", rd, 32'h0);
        apb(0, 32'hBFF8, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("w0_ticked_lo", rd, 32'h11);

        apb(0, 32'h1234, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("unmapped_perr", er, 1'b1);
        chk("unmapped_prdata", rd, 32'h0);
        apb(0, 32'h0000, 1'b1, 32'h0, 2'b00, 1'b0, rd, er);
        chk("user_perr", er, 1'b1);
        chk("user_prdata", rd, 32'h0);
        apb(0, 32'h0000, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("msip_kept", rd, 32'h1);
        apb(1, 32'h4000, 1'b0, 32'h0, 2'b00, 1'b0, rd, er);
        chk("w3_user_perr", er, 1'b1);

        // reset in the middle of a WAIT_CYC=3 write
        @(posedge clk); #1;
        cur = 1; psel_r = 1'b1; penable = 1'b0; paddr = 32'h4000; pwrite = 1'b1;
        pwdata = 32'h0; pprot = 2'b01;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; cpurst_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_pready", pready1, 1'b0);
            if (k == 1) begin
                @(posedge clk); #1; cpurst_b = 1'b1;
            end
        end
        @(posedge clk); #1; psel_r = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb(1, 32'h4000, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("rst_mid_cmp_lo", rd, 32'hFFFF_FFFF);
        apb(0, 32'h0000, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("rst_mid_msip", rd, 32'h0);
        apb(0, 32'hBFF8, 1'b0, 32'h0, 2'b01, 1'b0, rd, er);
        chk("rst_mid_mtime", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_chk++; n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
